// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: decoded items in, machine words out.
// Items are legality-checked; illegal ones become a NOP tagged as illegal.
package inst_encoder_pkg;
    typedef logic [4:0]  reg_t;
    typedef logic [31:0] data_t;
    typedef enum logic [5:0] {
        NO_INST, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        LB, LH, LW, LBU, LHU, JALR, SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU, LUI, AUIPC, JAL
    } instruction_t;
endpackage

module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  instruction_t     in_instruction,
    input  reg_t             in_rs1,
    input  reg_t             in_rs2,
    input  reg_t             in_rd,
    input  data_t            in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_illegal,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] illegal_count
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [2:0] F_NONE = 3'd0, F_R = 3'd1, F_I = 3'd2, F_SH = 3'd3;
    localparam logic [2:0] F_S = 3'd4, F_B = 3'd5, F_U = 3'd6, F_J = 3'd7;

    localparam logic [6:0] O_OP = 7'b0110011, O_IMM = 7'b0010011;
    localparam logic [6:0] O_LD = 7'b0000011, O_JALR = 7'b1100111;
    localparam logic [6:0] O_ST = 7'b0100011, O_BR = 7'b1100011;
    localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
    localparam logic [6:0] O_JAL = 7'b1101111;

    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic        alt;
    logic [31:0] imm;
    logic [31:0] raw;
    logic        bad;
    logic [31:0] enc_word;

    assign imm = in_imm;

    always_comb begin
        fmt = F_NONE;
        op  = '0;
        f3  = '0;
        alt = 1'b0;
        unique case (in_instruction)
            ADD:   begin fmt = F_R;  op = O_OP;  f3 = 3'd0; end
            SUB:   begin fmt = F_R;  op = O_OP;  f3 = 3'd0; alt = 1'b1; end
            SLL:   begin fmt = F_R;  op = O_OP;  f3 = 3'd1; end
            SLT:   begin fmt = F_R;  op = O_OP;  f3 = 3'd2; end
            SLTU:  begin fmt = F_R;  op = O_OP;  f3 = 3'd3; end
            XOR:   begin fmt = F_R;  op = O_OP;  f3 = 3'd4; end
            SRL:   begin fmt = F_R;  op = O_OP;  f3 = 3'd5; end
            SRA:   begin fmt = F_R;  op = O_OP;  f3 = 3'd5; alt = 1'b1; end
            OR:    begin fmt = F_R;  op = O_OP;  f3 = 3'd6; end
            AND:   begin fmt = F_R;  op = O_OP;  f3 = 3'd7; end
            ADDI:  begin fmt = F_I;  op = O_IMM; f3 = 3'd0; end
            SLTI:  begin fmt = F_I;  op = O_IMM; f3 = 3'd2; end
            SLTIU: begin fmt = F_I;  op = O_IMM; f3 = 3'd3; end
            XORI:  begin fmt = F_I;  op = O_IMM; f3 = 3'd4; end
            ORI:   begin fmt = F_I;  op = O_IMM; f3 = 3'd6; end
            ANDI:  begin fmt = F_I;  op = O_IMM; f3 = 3'd7; end
            SLLI:  begin fmt = F_SH; op = O_IMM; f3 = 3'd1; end
            SRLI:  begin fmt = F_SH; op = O_IMM; f3 = 3'd5; end
            SRAI:  begin fmt = F_SH; op = O_IMM; f3 = 3'd5; alt = 1'b1; end
            LB:    begin fmt = F_I;  op = O_LD;  f3 = 3'd0; end
            LH:    begin fmt = F_I;  op = O_LD;  f3 = 3'd1; end
            LW:    begin fmt = F_I;  op = O_LD;  f3 = 3'd2; end
            LBU:   begin fmt = F_I;  op = O_LD;  f3 = 3'd4; end
            LHU:   begin fmt = F_I;  op = O_LD;  f3 = 3'd5; end
            JALR:  begin fmt = F_I;  op = O_JALR; f3 = 3'd0; end
            SB:    begin fmt = F_S;  op = O_ST;  f3 = 3'd0; end
            SH:    begin fmt = F_S;  op = O_ST;  f3 = 3'd1; end
            SW:    begin fmt = F_S;  op = O_ST;  f3 = 3'd2; end
            BEQ:   begin fmt = F_B;  op = O_BR;  f3 = 3'd0; end
            BNE:   begin fmt = F_B;  op = O_BR;  f3 = 3'd1; end
            BLT:   begin fmt = F_B;  op = O_BR;  f3 = 3'd4; end
            BGE:   begin fmt = F_B;  op = O_BR;  f3 = 3'd5; end
            BLTU:  begin fmt = F_B;  op = O_BR;  f3 = 3'd6; end
            BGEU:  begin fmt = F_B;  op = O_BR;  f3 = 3'd7; end
            LUI:   begin fmt = F_U;  op = O_LUI; end
            AUIPC: begin fmt = F_U;  op = O_AUIPC; end
            JAL:   begin fmt = F_J;  op = O_JAL; end
            default: fmt = F_NONE;
        endcase
    end

    // Immediates must be exactly representable in the target field.
    always_comb begin
        raw = NOP;
        bad = 1'b0;
        case (fmt)
            F_R: raw = {1'b0, alt, 5'b0, in_rs2, in_rs1, f3, in_rd, op};
            F_I: begin
                raw = {imm[11:0], in_rs1, f3, in_rd, op};
                bad = imm[31:11] != {21{imm[11]}};
            end
            F_SH: begin
                raw = {1'b0, alt, 5'b0, imm[4:0], in_rs1, f3, in_rd, op};
                bad = |imm[31:5];
            end
            F_S: begin
                raw = {imm[11:5], in_rs2, in_rs1, f3, imm[4:0], op};
                bad = imm[31:11] != {21{imm[11]}};
            end
            F_B: begin
                raw = {imm[12], imm[10:5], in_rs2, in_rs1, f3,
                       imm[4:1], imm[11], op};
                bad = imm[0] | (imm[31:12] != {20{imm[12]}});
            end
            F_U: begin
                raw = {imm[31:12], in_rd, op};
                bad = |imm[11:0];
            end
            F_J: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, op};
                bad = imm[0] | (imm[31:20] != {12{imm[20]}});
            end
            default: bad = 1'b1;
        endcase
    end

    assign enc_word = bad ? NOP : raw;

    logic [32:0]   mem [OUT_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign out_word    = out_valid ? mem[rp[AW-1:0]][31:0] : '0;
    assign out_illegal = out_valid & mem[rp[AW-1:0]][32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
            enc_count     <= '0;
            illegal_count <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= {bad, enc_word};
                wp <= wp + PW'(1);
                enc_count <= enc_count + CNT_W'(1);
                if (bad && illegal_count != '1)
                    illegal_count <= illegal_count + CNT_W'(1);
            end
            if (pop) rp <= rp + PW'(1);
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder.
// A behavioural RV32I encoder and a word queue predict every output.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    instruction_t in_instruction = NO_INST;
    reg_t         in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    data_t        in_imm = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_word;
    logic         out_illegal;
    logic [15:0]  enc_count;
    logic [15:0]  illegal_count;

    int n_tests = 0;
    int n_fail  = 0;

    inst_encoder #(.OUT_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_illegal(out_illegal),
        .enc_count(enc_count), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: classify by kind, pack fields with arithmetic shifts.
    function automatic logic [32:0] ref_encode(instruction_t ins,
        logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [31:0] imm);
        int unsigned op, f3, f7, u, r1, r2, d, w;
        byte kind;
        longint sv;
        bit ok;
        op = 0; f3 = 0; f7 = 0; kind = "-"; ok = 0; w = 0;
        u = imm; r1 = rs1; r2 = rs2; d = rd;
        sv = longint'($signed(imm));
        case (ins)
            ADD:   begin kind = "R"; op = 'h33; f3 = 0; end
            SUB:   begin kind = "R"; op = 'h33; f3 = 0; f7 = 'h20; end
            SLL:   begin kind = "R"; op = 'h33; f3 = 1; end
            SLT:   begin kind = "R"; op = 'h33; f3 = 2; end
            SLTU:  begin kind = "R"; op = 'h33; f3 = 3; end
            XOR:   begin kind = "R"; op = 'h33; f3 = 4; end
            SRL:   begin kind = "R"; op = 'h33; f3 = 5; end
            SRA:   begin kind = "R"; op = 'h33; f3 = 5; f7 = 'h20; end
            OR:    begin kind = "R"; op = 'h33; f3 = 6; end
            AND:   begin kind = "R"; op = 'h33; f3 = 7; end
            ADDI:  begin kind = "I"; op = 'h13; f3 = 0; end
            SLTI:  begin kind = "I"; op = 'h13; f3 = 2; end
            SLTIU: begin kind = "I"; op = 'h13; f3 = 3; end
            XORI:  begin kind = "I"; op = 'h13; f3 = 4; end
            ORI:   begin kind = "I"; op = 'h13; f3 = 6; end
            ANDI:  begin kind = "I"; op = 'h13; f3 = 7; end
            SLLI:  begin kind = "H"; op = 'h13; f3 = 1; end
            SRLI:  begin kind = "H"; op = 'h13; f3 = 5; end
            SRAI:  begin kind = "H"; op = 'h13; f3 = 5; f7 = 'h20; end
            LB:    begin kind = "I"; op = 'h03; f3 = 0; end
            LH:    begin kind = "I"; op = 'h03; f3 = 1; end
            LW:    begin kind = "I"; op = 'h03; f3 = 2; end
            LBU:   begin kind = "I"; op = 'h03; f3 = 4; end
            LHU:   begin kind = "I"; op = 'h03; f3 = 5; end
            JALR:  begin kind = "I"; op = 'h67; f3 = 0; end
            SB:    begin kind = "S"; op = 'h23; f3 = 0; end
            SH:    begin kind = "S"; op = 'h23; f3 = 1; end
            SW:    begin kind = "S"; op = 'h23; f3 = 2; end
            BEQ:   begin kind = "B"; op = 'h63; f3 = 0; end
            BNE:   begin kind = "B"; op = 'h63; f3 = 1; end
            BLT:   begin kind = "B"; op = 'h63; f3 = 4; end
            BGE:   begin kind = "B"; op = 'h63; f3 = 5; end
            BLTU:  begin kind = "B"; op = 'h63; f3 = 6; end
            BGEU:  begin kind = "B"; op = 'h63; f3 = 7; end
            LUI:   begin kind = "U"; op = 'h37; end
            AUIPC: begin kind = "U"; op = 'h17; end
            JAL:   begin kind = "J"; op = 'h6F; end
            default: kind = "-";
        endcase
        case (kind)
            "R": begin
                ok = 1;
                w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                  | (d << 7) | op;
            end
            "I": begin
                ok = sv >= -2048 && sv <= 2047;
                w = ((u & 'hFFF) << 20) | (r1 << 15) | (f3 << 12)
                  | (d << 7) | op;
            end
            "H": begin
                ok = u < 32;
                w = (f7 << 25) | ((u & 31) << 20) | (r1 << 15)
                  | (f3 << 12) | (d << 7) | op;
            end
            "S": begin
                ok = sv >= -2048 && sv <= 2047;
                w = (((u >> 5) & 127) << 25) | (r2 << 20) | (r1 << 15)
                  | (f3 << 12) | ((u & 31) << 7) | op;
            end
            "B": begin
                ok = (u % 2 == 0) && sv >= -4096 && sv <= 4095;
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25)
                  | (r2 << 20) | (r1 << 15) | (f3 << 12)
                  | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | op;
            end
            "U": begin
                ok = (u % 4096) == 0;
                w = (u & 'hFFFFF000) | (d << 7) | op;
            end
            "J": begin
                ok = (u % 2 == 0) && sv >= -1048576 && sv <= 1048575;
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21)
                  | (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12)
                  | (d << 7) | op;
            end
            default: ok = 0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        step();
    endtask

    task automatic rand_item();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0)
            in_instruction = instruction_t'(6'($urandom_range(0, 63)));
        else
            in_instruction = instruction_t'(6'($urandom_range(1, 37)));
        in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom);
        in_rd  = 5'($urandom);
        case ($urandom_range(0, 5))
            0: in_imm = r;
            1: in_imm = 32'($urandom_range(0, 40));
            2: in_imm = {{20{r[11]}}, r[11:0]};
            3: in_imm = {{19{r[12]}}, r[12:1], ($urandom_range(0, 7) == 0)};
            4: in_imm = {{11{r[20]}}, r[20:1], 1'b0};
            default: in_imm = r & 32'hFFFF_F000;
        endcase
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
                     in_ready, out_valid);
        end
        n_tests++;
        if (out_word !== 32'h0 || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: word=%h ill=%b want 0/0",
                     out_word, out_illegal);
        end
        n_tests++;
        if (enc_count !== 16'd0 || illegal_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: enc=%0d ill=%0d want 0/0",
                     enc_count, illegal_count);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_encoding();
        instruction_t ins[7] = '{ADDI, ADD, SUB, SW, BEQ, JAL, LUI};
        int r1[7] = '{0, 1, 1, 1, 1, 0, 0};
        int r2[7] = '{0, 2, 2, 2, 2, 0, 0};
        int rd[7] = '{1, 3, 3, 0, 0, 1, 5};
        int im[7] = '{5, 0, 0, 8, 8, 16, 'h12345000};
        logic [31:0] ex[7] = '{32'h00500093, 32'h002081B3, 32'h402081B3,
                               32'h0020A423, 32'h00208463, 32'h010000EF,
                               32'h123452B7};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_instruction = ins[i];
            in_rs1 = 5'(r1[i]);
            in_rs2 = 5'(r2[i]);
            in_rd  = 5'(rd[i]);
            in_imm = 32'(im[i]);
            step();
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || out_word !== ex[i]
                || out_illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL enc_%0d: v=%b word=%h ill=%b want 1/%h/0",
                         i, out_valid, out_word, out_illegal, ex[i]);
            end
            step();
        end
    endtask

    task automatic test_illegal();
        instruction_t ins[3] = '{ADDI, BEQ, NO_INST};
        int im[3] = '{'h800, 3, 0};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instruction = ins[i];
            in_rs1 = 5'd1;
            in_rs2 = 5'd2;
            in_rd  = 5'd3;
            in_imm = 32'(im[i]);
            step();
            in_valid = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || out_word !== 32'h13
                || out_illegal !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal_%0d: v=%b word=%h ill=%b want 1/13/1",
                         i, out_valid, out_word, out_illegal);
            end
            step();
        end
        n_tests++;
        if (enc_count !== 16'd3 || illegal_count !== 16'd3) begin
            n_fail++;
            $display("FAIL illegal_cnt: enc=%0d ill=%0d want 3/3",
                     enc_count, illegal_count);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instruction = ADDI;
            in_rs1 = 5'd0;
            in_rd  = 5'd1;
            in_imm = 32'(i + 1);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        n_tests++;
        if (acc != 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: accepted=%0d in_ready=%b want 2/0",
                     acc, in_ready);
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_word !== 32'h00100093) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: v=%b word=%h want 1/00100093",
                         i, out_valid, out_word);
            end
            step();
        end
        out_ready = 1'b1;
        n_tests++;
        if (out_word !== 32'h00100093) begin
            n_fail++;
            $display("FAIL bp_drain0: word=%h want 00100093", out_word);
        end
        step();
        n_tests++;
        if (out_word !== 32'h00200093 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain1: word=%h in_ready=%b want 00200093/1",
                     out_word, in_ready);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_empty: v=%b in_ready=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] q[$];
        int sent, got, cyc, ill;
        sent = 0; got = 0; cyc = 0; ill = 0;
        do_reset();
        out_ready = 1'b1;
        while (got < 100 && cyc < 300) begin
            if (sent < 100) begin
                in_valid = 1'b1;
                rand_item();
            end else begin
                in_valid = 1'b0;
            end
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready: cyc=%0d in_ready=%b want 1",
                         cyc, in_ready);
            end
            if (out_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: cyc=%0d word=%h want none",
                             cyc, out_word);
                end else begin
                    if ({out_illegal, out_word} !== q[0]) begin
                        n_fail++;
                        $display("FAIL b2b_word: got=%h want=%h",
                                 {out_illegal, out_word}, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_encode(in_instruction, in_rs1, in_rs2,
                                       in_rd, in_imm));
                ill += int'(q[q.size()-1][32]);
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (cyc != 101) begin
            n_fail++;
            $display("FAIL b2b_cycles: got %0d words in %0d cycles want 100/101",
                     got, cyc);
        end
        n_tests++;
        if (enc_count !== 16'd100 || illegal_count !== 16'(ill)) begin
            n_fail++;
            $display("FAIL b2b_cnt: enc=%0d ill=%0d want 100/%0d",
                     enc_count, illegal_count, ill);
        end
    endtask

    task automatic test_mixed();
        logic [32:0] q[$];
        int acc, ill;
        acc = 0; ill = 0;
        do_reset();
        for (int c = 0; c < 460; c++) begin
            in_valid  = (c < 400) && ($urandom_range(0, 2) != 0);
            out_ready = (c >= 400) || ($urandom_range(0, 1) != 0);
            rand_item();
            n_tests++;
            if (out_valid !== (q.size() != 0)
                || in_ready !== (q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL mix_flags: cyc=%0d v=%b rdy=%b occ=%0d",
                         c, out_valid, in_ready, q.size());
            end
            if (out_valid && q.size() != 0) begin
                n_tests++;
                if ({out_illegal, out_word} !== q[0]) begin
                    n_fail++;
                    $display("FAIL mix_word: cyc=%0d got=%h want=%h",
                             c, {out_illegal, out_word}, q[0]);
                end
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_encode(in_instruction, in_rs1, in_rs2,
                                       in_rd, in_imm));
                ill += int'(q[q.size()-1][32]);
                acc++;
            end
            step();
        end
        in_valid = 1'b0;
        n_tests++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mix_drain: left=%0d v=%b want 0/0",
                     q.size(), out_valid);
        end
        n_tests++;
        if (enc_count !== 16'(acc) || illegal_count !== 16'(ill)) begin
            n_fail++;
            $display("FAIL mix_cnt: enc=%0d ill=%0d want %0d/%0d",
                     enc_count, illegal_count, acc, ill);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instruction = ADDI;
        in_rd = 5'd1;
        in_rs1 = 5'd0;
        in_imm = 32'd7;
        step();
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: v=%b rdy=%b want 1/0", out_valid, in_ready);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_word !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_flush: v=%b word=%h rdy=%b want 0/0/1",
                     out_valid, out_word, in_ready);
        end
        n_tests++;
        if (enc_count !== 16'd0 || illegal_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_cnt: enc=%0d ill=%0d want 0/0",
                     enc_count, illegal_count);
        end
        #1;
        rstn = 1'b1;
        step();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instruction = ADD;
        in_rd = 5'd3;
        in_rs1 = 5'd1;
        in_rs2 = 5'd2;
        in_imm = 32'd0;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_word !== 32'h002081B3
            || enc_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_after: v=%b word=%h enc=%0d want 1/002081b3/1",
                     out_valid, out_word, enc_count);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_mixed();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder: accepts decoded instruction items (the `instruction_t` / register / immediate fields of `instruction_item_t`) and emits the corresponding 32-bit machine words. It is the inverse of the core's decode path. The verification environment places it between the instruction-item generator and the instruction-memory loader, so randomized item streams become loadable programs. Input and output use valid/ready handshakes with a small output FIFO and per-item legality checking.

## Interface

Parameters:
- `OUT_DEPTH`, default 2: output FIFO depth (power of two, ≥2).
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`, in, 1: clock; all logic is rising-edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input item valid.
- `in_ready`, out, 1: input can be accepted.
- `in_instruction`, in, `instruction_t` (6): operation.
- `in_rs1`, `in_rs2`, `in_rd`, in, `reg_t` (5 each): register fields.
- `in_imm`, in, `data_t` (32): full immediate value (byte offset for branches and jumps; full 32-bit value for LUI/AUIPC).
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: consumer accepts the word.
- `out_word`, out, 32: encoded instruction.
- `out_illegal`, out, 1: the item failed a legality check; the word is the NOP 0x00000013.
- `enc_count`, out, `CNT_W`: number of accepted items; wraps.
- `illegal_count`, out, `CNT_W`: number of illegal items; saturates at all-ones.

## Operation

- Accept occurs when `in_valid && in_ready`. The word is encoded combinationally from the inputs and pushed together with its illegal flag into the FIFO.
- `in_ready = !full`. It depends only on registered FIFO occupancy; there is no combinational path from `out_ready`.
- Pop occurs when `out_valid && out_ready`. `out_valid = !empty`. `out_word` and `out_illegal` show the FIFO head.
- Opcodes:
  - OP 0110011: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111. funct7 is 0100000 for SUB and SRA, otherwise 0.
  - OP-IMM 0010011: ADDI 000, SLTI 010, SLTIU 011, XORI 100, ORI 110, ANDI 111, SLLI 001, SRLI/SRAI 101. SRAI sets bit 30. Shift amount is `imm[4:0]`.
  - LOAD 0000011: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - JALR 1100111, funct3 000.
  - STORE 0100011: SB 000, SH 001, SW 010.
  - BRANCH 1100011: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - LUI 0110111 and AUIPC 0010111 use `imm[31:12]`.
  - JAL 1101111.
- Field packing follows standard RV32I R/I/S/B/U/J layouts. Unused register fields are ignored: rs2 for I-type, rd for S/B-type.
- An item is illegal, forcing `out_word` = 0x00000013 and `out_illegal` = 1, when any of these hold:
  - `in_instruction` is NO_INST or an unenumerated value.
  - I/S immediate is not a sign-extended 12-bit value.
  - Shift immediate has `imm[31:5]` ≠ 0.
  - B immediate is odd or is not a sign-extended 13-bit value.
  - J immediate is odd or is not a sign-extended 21-bit value.
  - U immediate has `imm[11:0]` ≠ 0.
- `enc_count` increments on every accept, legal or illegal. `illegal_count` increments on illegal accepts and holds at all-ones once saturated.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `out_word`=0, `out_illegal`=0, `enc_count`=0, `illegal_count`=0. The FIFO pointers are cleared.
- Latency: a word accepted in cycle N is visible with `out_valid`=1 in cycle N+1.
- Throughput: one item per cycle sustained when `out_ready` is held at 1.
- Simultaneous push and pop: occupancy is unchanged and ordering is preserved. When full, `in_ready`=0 for that cycle even if a pop occurs; it rises the next cycle.
- Holding rule: while `out_valid && !out_ready`, `out_word` and `out_illegal` must remain stable.
- Pointers wrap modulo `OUT_DEPTH`.
- Reset asserted mid-stream discards all buffered words immediately, with no partial output.

## Test plan

- Encoding: ADDI x1,x0,5 → 0x00500093; ADD x3,x1,x2 → 0x002081B3; SUB x3,x1,x2 → 0x402081B3. Each appears one cycle after accept.
- Encoding: SW x2,8(x1) → 0x0020A423; BEQ x1,x2,+8 → 0x00208463; JAL x1,+16 → 0x010000EF; LUI x5,0x12345000 → 0x123452B7.
- Illegal items: ADDI imm=0x800, BEQ imm=3, NO_INST → each gives 0x00000013 with `out_illegal`=1. `illegal_count`=3 and `enc_count`=3 afterwards.
- Backpressure: with `out_ready`=0, offer 3 items. Exactly 2 are accepted, `in_ready` falls, and the head stays stable. Raising `out_ready` drains the words in order and `in_ready` returns.
- Streaming: 100 back-to-back items with `out_ready`=1 → 100 words in 101 cycles. A mix of push and pop every cycle shows no loss or reordering.
- Reset mid-stream with 2 words buffered → `out_valid`=0 and counters are 0 immediately. The first item after reset encodes correctly.
